pdp_mem_responder: RTL

- Responder end of the PDP-8 memory interface: serves the instruction-fetch read channel (ifu_rd_*), the execute read channel (exec_rd_*) and the execute write channel (exec_wr_*) from one word-addressed array.
- Read latency is configurable. Each read channel has a response-valid strobe, so decode and exec can be tested against non-zero memory latency.
- A valid/ready load port lets the bench preload programs without hierarchical memory pokes.

---
 rtl/pdp8_pkg.sv | 31 +++
 rtl/pdp_rd_delay_pipe.sv | 43 ++++
 rtl/pdp_mem_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pdp8_pkg.sv
// Shared types and constants for the PDP-8 memory responder and its read-response pipes.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

    localparam int PDP_ADDR_WIDTH     = `ADDR_WIDTH;
    localparam int PDP_DATA_WIDTH     = `DATA_WIDTH;
    localparam int PDP_MEM_MAX_RD_LAT = 4;

    typedef struct packed {
        logic                      valid;
        logic [PDP_DATA_WIDTH-1:0] data;
    } mem_rd_pipe_s;

    // Which port owns the array write this cycle; exec always wins over the bench load port.
    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,
        WSRC_EXEC = 2'd1,
        WSRC_LOAD = 2'd2
    } wr_src_e;

    function automatic bit rd_lat_legal(input int lat);
        return (lat >= 1) && (lat <= PDP_MEM_MAX_RD_LAT);
    endfunction

endpackage

// File: rtl/pdp_rd_delay_pipe.sv
// Read-response delay line: a word sampled at edge t appears on out_s at edge t+READ_LAT,
// with a one-cycle valid strobe; the data field holds between responses.
module pdp_rd_delay_pipe
    import pdp8_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  mem_rd_pipe_s in_s,
    output mem_rd_pipe_s out_s
);

    mem_rd_pipe_s [READ_LAT-1:0] stage_q;
    mem_rd_pipe_s [READ_LAT-1:0] stage_d;
    mem_rd_pipe_s                resp_q;
    mem_rd_pipe_s                resp_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_s;
        for (int i = 1; i < READ_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end

        resp_d.valid = stage_q[READ_LAT-1].valid;
        resp_d.data  = stage_q[READ_LAT-1].valid ? stage_q[READ_LAT-1].data : resp_q.data;
    end

    // NOTE: state is updated with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= '0;
            resp_q  <= '0;
        end else begin
            stage_q <= stage_d;
            resp_q  <= resp_d;
        end
    end

    assign out_s = resp_q;

endmodule

// File: rtl/pdp_mem_responder.sv
// PDP-8 memory responder: one word array serving fetch reads, exec reads, exec writes and a
// bench preload port, with write-first bypass and a registered read/write collision flag.
module pdp_mem_responder
    import pdp8_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_valid,
    input  logic                  exec_rd_req,
    input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_rd_valid,
    input  logic                  exec_wr_req,
    input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
    input  logic [DATA_WIDTH-1:0] exec_wr_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  rd_wr_collide
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if (!rd_lat_legal(READ_LAT)) begin : g_bad_read_lat
        $error("pdp_mem_responder: READ_LAT=%0d outside 1..%0d", READ_LAT, PDP_MEM_MAX_RD_LAT);
    end
    if (DATA_WIDTH != PDP_DATA_WIDTH) begin : g_bad_data_width
        $error("pdp_mem_responder: DATA_WIDTH=%0d must match pipe width %0d",
               DATA_WIDTH, PDP_DATA_WIDTH);
    end

    logic [DATA_WIDTH-1:0] mem_array [DEPTH];

    wr_src_e               wr_src;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    mem_rd_pipe_s          ifu_pipe_in;
    mem_rd_pipe_s          ifu_pipe_out;
    mem_rd_pipe_s          exec_pipe_in;
    mem_rd_pipe_s          exec_pipe_out;

    logic                  rd_wr_collide_q;
    logic                  rd_wr_collide_d;

    assign load_ready = !reset && !exec_wr_req;

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        wr_src  = WSRC_NONE;
        wr_addr = exec_wr_addr;
        wr_data = exec_wr_data;
        if (!reset) begin
            if (exec_wr_req) begin
                wr_src = WSRC_EXEC;
            end else if (load_valid) begin
                wr_src  = WSRC_LOAD;
                wr_addr = load_addr;
                wr_data = load_data;
            end
        end
    end

    assign wr_en = (wr_src != WSRC_NONE);

    // NOTE: the array has no reset branch; program contents must survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_array[wr_addr] <= wr_data;
        end
    end

    // Write-first: a same-cycle write to the read address supplies the sampled word.
    always_comb begin
        ifu_pipe_in.valid  = ifu_rd_req;
        ifu_pipe_in.data   = (wr_en && (wr_addr == ifu_rd_addr)) ? wr_data
                                                                  : mem_array[ifu_rd_addr];
        exec_pipe_in.valid = exec_rd_req;
        exec_pipe_in.data  = (wr_en && (wr_addr == exec_rd_addr)) ? wr_data
                                                                   : mem_array[exec_rd_addr];
    end

    always_comb begin
        rd_wr_collide_d = exec_wr_req &&
                          ((ifu_rd_req  && (ifu_rd_addr  == exec_wr_addr)) ||
                           (exec_rd_req && (exec_rd_addr == exec_wr_addr)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_wr_collide_q <= 1'b0;
        end else begin
            rd_wr_collide_q <= rd_wr_collide_d;
        end
    end

    assign rd_wr_collide = rd_wr_collide_q;

    pdp_rd_delay_pipe #(
        .READ_LAT (READ_LAT)
    ) u_ifu_pipe (
        .clk   (clk),
        .reset (reset),
        .in_s  (ifu_pipe_in),
        .out_s (ifu_pipe_out)
    );

    pdp_rd_delay_pipe #(
        .READ_LAT (READ_LAT)
    ) u_exec_pipe (
        .clk   (clk),
        .reset (reset),
        .in_s  (exec_pipe_in),
        .out_s (exec_pipe_out)
    );

    assign ifu_rd_valid  = ifu_pipe_out.valid;
    assign ifu_rd_data   = ifu_pipe_out.data;
    assign exec_rd_valid = exec_pipe_out.valid;
    assign exec_rd_data  = exec_pipe_out.data;

endmodule
